// File: rtl/line_pkg.sv
// Shared types and constants for the Bresenham line stepper.
package line_pkg;

    localparam int DEFAULT_WIDTH = 13;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } line_state_e;

    // Two extra bits hold |x1-x0| and the error term without overflow.
    function automatic int errw_for(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/bresenham_line_stepper_if.sv
// Command and pixel-stream bundle for bresenham_line_stepper.
// LINE_PATTERN_EN adds the 16-bit dash pattern input.
interface bresenham_line_stepper_if #(parameter int WIDTH = line_pkg::DEFAULT_WIDTH);
    logic             start;
    logic [WIDTH-1:0] x0;
    logic [WIDTH-1:0] y0;
    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] y1;
`ifdef LINE_PATTERN_EN
    logic [15:0]      pattern;
`endif
    logic [WIDTH-1:0] pix_x;
    logic [WIDTH-1:0] pix_y;
    logic             pix_valid;
    logic             pix_ready;
    logic             busy;
    logic             done;

    modport master (
        output start, x0, y0, x1, y1, pix_ready,
`ifdef LINE_PATTERN_EN
        output pattern,
`endif
        input  pix_x, pix_y, pix_valid, busy, done
    );

    modport slave (
        input  start, x0, y0, x1, y1, pix_ready,
`ifdef LINE_PATTERN_EN
        input  pattern,
`endif
        output pix_x, pix_y, pix_valid, busy, done
    );
endinterface

// File: rtl/bresenham_step_core.sv
// Combinational single Bresenham step: next pixel and next error term
// from the current pixel, error, deltas, step directions and steepness.
module bresenham_step_core #(
    parameter int WIDTH = line_pkg::DEFAULT_WIDTH,
    parameter int ERRW  = line_pkg::errw_for(WIDTH)
) (
    input  logic [WIDTH-1:0]       x_i,
    input  logic [WIDTH-1:0]       y_i,
    input  logic signed [ERRW-1:0] err_i,
    input  logic signed [ERRW-1:0] dmajor_i,
    input  logic signed [ERRW-1:0] dminor_i,
    input  logic                   sx_neg_i,
    input  logic                   sy_neg_i,
    input  logic                   steep_i,
    output logic [WIDTH-1:0]       x_o,
    output logic [WIDTH-1:0]       y_o,
    output logic signed [ERRW-1:0] err_o
);
    logic signed [ERRW-1:0] err_n;
    logic                   minor_step;
    logic                   x_adv;
    logic                   y_adv;
    logic [WIDTH-1:0]       x_step;
    logic [WIDTH-1:0]       y_step;

    assign err_n      = err_i - dminor_i;
    assign minor_step = err_n[ERRW-1];
    assign err_o      = minor_step ? (err_n + dmajor_i) : err_n;

    // The major axis always advances; the minor axis only on error underflow.
    assign x_adv  = steep_i ? minor_step : 1'b1;
    assign y_adv  = steep_i ? 1'b1 : minor_step;
    assign x_step = sx_neg_i ? {WIDTH{1'b1}} : WIDTH'(1);
    assign y_step = sy_neg_i ? {WIDTH{1'b1}} : WIDTH'(1);

    assign x_o = x_adv ? (x_i + x_step) : x_i;
    assign y_o = y_adv ? (y_i + y_step) : y_i;
endmodule

// File: rtl/bresenham_line_stepper.sv
// Eight-octant Bresenham line engine emitting a valid/ready pixel stream.
// Optional LINE_PATTERN_EN: 16-bit dash pattern suppresses pixels with a 0 bit.
//
// state  | meaning
// IDLE   | waiting for start, endpoints latched on accept
// SETUP  | deltas, directions, error seed; first pixel loaded
// RUN    | one pixel per handshake (or per cycle for masked pixels)
// FINISH | one-cycle done pulse
module bresenham_line_stepper
    import line_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int ERRW  = errw_for(WIDTH)
) (
    input logic                     clk,
    input logic                     rst,
    bresenham_line_stepper_if.slave bus
);
    line_state_e            state_q, state_d;
    logic [WIDTH-1:0]       x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [WIDTH-1:0]       pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic                   pix_valid_q, pix_valid_d;
    logic signed [ERRW-1:0] err_q, err_d, dmajor_q, dmajor_d, dminor_q, dminor_d;
    logic [ERRW-1:0]        rem_q, rem_d;
    logic                   steep_q, steep_d, sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
`ifdef LINE_PATTERN_EN
    logic [15:0]            pattern_q, pattern_d;
    logic [3:0]             idx_q, idx_d;
    logic [3:0]             idx_n;
`endif

    logic signed [ERRW-1:0] ddx, ddy, adx, ady;
    logic                   steep_w;
    logic [WIDTH-1:0]       nx, ny;
    logic signed [ERRW-1:0] nerr;
    logic                   advance;

    assign ddx     = ERRW'($signed(x1_q)) - ERRW'($signed(x0_q));
    assign ddy     = ERRW'($signed(y1_q)) - ERRW'($signed(y0_q));
    assign adx     = ddx[ERRW-1] ? -ddx : ddx;
    assign ady     = ddy[ERRW-1] ? -ddy : ddy;
    assign steep_w = ady > adx;

    bresenham_step_core #(.WIDTH(WIDTH), .ERRW(ERRW)) u_step (
        .x_i      (pix_x_q),
        .y_i      (pix_y_q),
        .err_i    (err_q),
        .dmajor_i (dmajor_q),
        .dminor_i (dminor_q),
        .sx_neg_i (sx_neg_q),
        .sy_neg_i (sy_neg_q),
        .steep_i  (steep_q),
        .x_o      (nx),
        .y_o      (ny),
        .err_o    (nerr)
    );

    // A masked pixel (valid low in RUN) advances without waiting for ready.
    assign advance = pix_valid_q ? bus.pix_ready : 1'b1;
`ifdef LINE_PATTERN_EN
    assign idx_n = idx_q + 4'd1;
`endif

    always_comb begin
        state_d     = state_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_valid_d = pix_valid_q;
        err_d       = err_q;
        dmajor_d    = dmajor_q;
        dminor_d    = dminor_q;
        rem_d       = rem_q;
        steep_d     = steep_q;
        sx_neg_d    = sx_neg_q;
        sy_neg_d    = sy_neg_q;
`ifdef LINE_PATTERN_EN
        pattern_d   = pattern_q;
        idx_d       = idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x0_d    = bus.x0;
                    y0_d    = bus.y0;
                    x1_d    = bus.x1;
                    y1_d    = bus.y1;
`ifdef LINE_PATTERN_EN
                    pattern_d = bus.pattern;
`endif
                    state_d = SETUP;
                end
            end
            SETUP: begin
                steep_d  = steep_w;
                sx_neg_d = ddx[ERRW-1];
                sy_neg_d = ddy[ERRW-1];
                dmajor_d = steep_w ? ady : adx;
                dminor_d = steep_w ? adx : ady;
                err_d    = (steep_w ? ady : adx) >>> 1;
                rem_d    = steep_w ? ady : adx;
                pix_x_d  = x0_q;
                pix_y_d  = y0_q;
`ifdef LINE_PATTERN_EN
                idx_d       = 4'd0;
                pix_valid_d = pattern_q[0];
`else
                pix_valid_d = 1'b1;
`endif
                state_d  = RUN;
            end
            RUN: begin
                if (advance) begin
                    if (rem_q == '0) begin
                        pix_valid_d = 1'b0;
                        state_d     = FINISH;
                    end else begin
                        pix_x_d = nx;
                        pix_y_d = ny;
                        err_d   = nerr;
                        rem_d   = rem_q - 1'b1;
`ifdef LINE_PATTERN_EN
                        idx_d       = idx_n;
                        pix_valid_d = pattern_q[idx_n];
`else
                        pix_valid_d = 1'b1;
`endif
                    end
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x0_q        <= '0;
            y0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_valid_q <= 1'b0;
            err_q       <= '0;
            dmajor_q    <= '0;
            dminor_q    <= '0;
            rem_q       <= '0;
            steep_q     <= 1'b0;
            sx_neg_q    <= 1'b0;
            sy_neg_q    <= 1'b0;
`ifdef LINE_PATTERN_EN
            pattern_q   <= '0;
            idx_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_valid_q <= pix_valid_d;
            err_q       <= err_d;
            dmajor_q    <= dmajor_d;
            dminor_q    <= dminor_d;
            rem_q       <= rem_d;
            steep_q     <= steep_d;
            sx_neg_q    <= sx_neg_d;
            sy_neg_q    <= sy_neg_d;
`ifdef LINE_PATTERN_EN
            pattern_q   <= pattern_d;
            idx_q       <= idx_d;
`endif
        end
    end

    assign bus.pix_x     = pix_x_q;
    assign bus.pix_y     = pix_y_q;
    assign bus.pix_valid = pix_valid_q;
    assign bus.busy      = (state_q == SETUP) || (state_q == RUN);
    assign bus.done      = (state_q == FINISH);
endmodule

// File: tb/tb_bresenham_line_stepper.sv
// Directed bench for bresenham_line_stepper: octants, degenerate line,
// backpressure, mid-line reset and (with LINE_PATTERN_EN) dash patterns.
module tb_bresenham_line_stepper;
    import line_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bresenham_line_stepper_if #(.WIDTH(13)) bus ();
    bresenham_line_stepper #(.WIDTH(13)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int px_q[$];
    int py_q[$];
    int done_k;
    int first_k;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sval(input logic [12:0] v);
        return int'($signed(v));
    endfunction

    // Cycle k counts from the cycle after start was sampled (k=1 is SETUP).
    // ready_mode 0: ready always high; 1: ready high on k=2,5,8,... (1,0,0 repeat).
    task automatic drive_line(input int x0, input int y0, input int x1, input int y1,
                              input int ready_mode);
        bit stalled;
        int sx, sy;
        px_q.delete();
        py_q.delete();
        done_k  = -1;
        first_k = -1;
        stalled = 1'b0;
        sx = 0;
        sy = 0;
        @(negedge clk);
        bus.x0 = x0[12:0];
        bus.y0 = y0[12:0];
        bus.x1 = x1[12:0];
        bus.y1 = y1[12:0];
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            bus.pix_ready = (ready_mode == 0) ? 1'b1 : (k % 3 == 2);
            if (k == 1) check_eq("busy_in_setup", int'(bus.busy), 1);
            if (stalled) begin
                check_eq("stall_valid", int'(bus.pix_valid), 1);
                check_eq("stall_x", sval(bus.pix_x), sx);
                check_eq("stall_y", sval(bus.pix_y), sy);
            end
            stalled = bus.pix_valid && !bus.pix_ready;
            sx = sval(bus.pix_x);
            sy = sval(bus.pix_y);
            if (bus.pix_valid && first_k < 0) first_k = k;
            if (bus.pix_valid && bus.pix_ready) begin
                px_q.push_back(sval(bus.pix_x));
                py_q.push_back(sval(bus.pix_y));
            end
            if (bus.done) begin
                done_k = k;
                check_eq("busy_at_done", int'(bus.busy), 0);
                break;
            end
            @(negedge clk);
        end
        bus.pix_ready = 1'b1;
        if (done_k < 0) check_eq("done_timeout", 0, 1);
    endtask

    task automatic compare_pixels(input string tag, input int ex[$], input int ey[$]);
        check_eq({tag, "_count"}, px_q.size(), ex.size());
        for (int i = 0; i < ex.size(); i++) begin
            if (i < px_q.size()) begin
                check_eq({tag, "_x"}, px_q[i], ex[i]);
                check_eq({tag, "_y"}, py_q[i], ey[i]);
            end
        end
    endtask

    initial begin
        int ex[$];
        int ey[$];
        int n;
        int seen_done;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.x0 = '0;
        bus.y0 = '0;
        bus.x1 = '0;
        bus.y1 = '0;
        bus.pix_ready = 1'b1;
`ifdef LINE_PATTERN_EN
        bus.pattern = 16'hFFFF;
`endif
        repeat (3) @(negedge clk);
        check_eq("rst_pix_valid", int'(bus.pix_valid), 0);
        check_eq("rst_pix_x", sval(bus.pix_x), 0);
        check_eq("rst_pix_y", sval(bus.pix_y), 0);
        check_eq("rst_busy", int'(bus.busy), 0);
        check_eq("rst_done", int'(bus.done), 0);
        rst = 1'b0;

        // Shallow octant
        drive_line(0, 0, 5, 2, 0);
        ex = '{0, 1, 2, 3, 4, 5};
        ey = '{0, 0, 1, 1, 2, 2};
        compare_pixels("shallow", ex, ey);
        check_eq("shallow_first_valid", first_k, 2);
        check_eq("shallow_done_cycle", done_k, 8);

        // Steep, both directions negative
        drive_line(3, 4, 1, -1, 0);
        ex = '{3, 3, 2, 2, 1, 1};
        ey = '{4, 3, 2, 1, 0, -1};
        compare_pixels("steep_neg", ex, ey);
        check_eq("steep_neg_done_cycle", done_k, 8);

        // Degenerate
        drive_line(7, 7, 7, 7, 0);
        ex = '{7};
        ey = '{7};
        compare_pixels("degen", ex, ey);
        check_eq("degen_first_valid", first_k, 2);
        check_eq("degen_done_cycle", done_k, 3);

        // Backpressure: handshakes at k=2,5,8,11
        drive_line(0, 0, 3, 3, 1);
        ex = '{0, 1, 2, 3};
        ey = '{0, 1, 2, 3};
        compare_pixels("bp", ex, ey);
        check_eq("bp_done_cycle", done_k, 12);

        // Reset mid-line
        @(negedge clk);
        bus.x0 = 13'd0;
        bus.y0 = 13'd0;
        bus.x1 = 13'd100;
        bus.y1 = 13'd0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        for (int k = 0; k < 200; k++) begin
            if (bus.pix_valid && bus.pix_ready) n++;
            if (n == 10) break;
            @(negedge clk);
        end
        check_eq("midrst_pixels_before", n, 10);
        check_eq("midrst_x_before", sval(bus.pix_x), 9);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_pix_valid", int'(bus.pix_valid), 0);
        check_eq("midrst_pix_x", sval(bus.pix_x), 0);
        check_eq("midrst_pix_y", sval(bus.pix_y), 0);
        check_eq("midrst_busy", int'(bus.busy), 0);
        check_eq("midrst_done", int'(bus.done), 0);
        seen_done = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.done || bus.pix_valid) seen_done++;
        end
        check_eq("midrst_quiet", seen_done, 0);

        drive_line(0, 0, 5, 2, 0);
        ex = '{0, 1, 2, 3, 4, 5};
        ey = '{0, 0, 1, 1, 2, 2};
        compare_pixels("after_rst", ex, ey);
        check_eq("after_rst_done_cycle", done_k, 8);

`ifdef LINE_PATTERN_EN
        bus.pattern = 16'h5555;
        drive_line(0, 0, 7, 0, 0);
        ex = '{0, 2, 4, 6};
        ey = '{0, 0, 0, 0};
        compare_pixels("pattern", ex, ey);
        check_eq("pattern_done_cycle", done_k, 10);
        bus.pattern = 16'hFFFF;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
